// File: rtl/cpu_debug_monitor_pkg.sv
// Shared types and sizing helpers for the CPU debug monitor.
package cpu_dbg_pkg;

    typedef enum logic [1:0] {CK_IDLE, CK_HIGH, CK_LOW} ck_state_e;

    typedef enum logic [1:0] {D_IDLE, D_LOAD, D_START, D_WAIT} disp_state_e;

    // Address bytes (MSB first) followed by one data byte.
    function automatic int unsigned bytes_per_entry(input int unsigned aw);
        return aw / 8 + 1;
    endfunction

    // Stored trace entry: {rw, ab, db}.
    function automatic int unsigned entry_width(input int unsigned aw);
        return aw + 9;
    endfunction

endpackage

// File: rtl/cpu_debug_monitor_if.sv
// CPU bus and LCD write handshake seen by the debug monitor.
interface cpu_debug_monitor_if #(
    parameter int unsigned AW = 16
) ();
    logic [AW-1:0] cpu_ab;
    logic [7:0]    cpu_db;
    logic          cpu_rw;
    logic          cpu_sync;
    logic          phi0_out;
    logic [7:0]    lcd_data;
    logic          lcd_write_start;
    logic          lcd_write_done;

    modport master (
        input  cpu_ab, cpu_db, cpu_rw, cpu_sync, lcd_write_done,
        output phi0_out, lcd_data, lcd_write_start
    );

    modport slave (
        output cpu_ab, cpu_db, cpu_rw, cpu_sync, lcd_write_done,
        input  phi0_out, lcd_data, lcd_write_start
    );
endinterface

// File: rtl/cpu_debug_monitor_btn_debounce.sv
// Button synchroniser + stability filter; emits a 1-clk pulse on each accepted press.
module btn_debounce #(
    parameter int unsigned DEB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_L,
    input  logic btn_i,
    output logic pulse_o
);
    localparam int unsigned CW = $clog2(DEB_CYCLES + 1);

    logic          sync1_q, sync2_q, level_q, level_dly_q, pulse_q;
    logic [CW-1:0] cnt_q;

    // Level follows the synchronised input only after DEB_CYCLES unchanged samples.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            pulse_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync1_q     <= btn_i;
            sync2_q     <= sync1_q;
            level_dly_q <= level_q;
            pulse_q     <= level_q & ~level_dly_q;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                level_q <= sync2_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/cpu_debug_monitor.sv
// CPU bring-up monitor: phi0 generation, bus-cycle trace, LCD trace dump.
// Optional breakpoint logic is enabled by CPU_DEBUG_MONITOR_BREAKPOINT_EN.
module cpu_debug_monitor
    import cpu_dbg_pkg::*;
#(
    parameter int unsigned AW          = 16,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned DEB_CYCLES  = 1000000,
    parameter int unsigned HALF_CYCLES = 4
) (
    input  logic                       clk,
    input  logic                       rst_L,
    input  logic                       btn_step,
    input  logic                       btn_run,
    input  logic                       btn_show,
    input  logic                       btn_clear,
    cpu_debug_monitor_if.master        bus,
`ifdef CPU_DEBUG_MONITOR_BREAKPOINT_EN
    input  logic [AW-1:0]              bp_addr,
    output logic                       bp_hit,
`endif
    output logic                       running,
    output logic [$clog2(DEPTH+1)-1:0] trace_count,
    output logic                       overflow,
    output logic                       dumping
);
    localparam int unsigned BPE  = bytes_per_entry(AW);
    localparam int unsigned EW   = entry_width(AW);
    localparam int unsigned PW   = $clog2(DEPTH);
    localparam int unsigned CNTW = $clog2(DEPTH + 1);
    localparam int unsigned HW   = $clog2(HALF_CYCLES + 1);
    localparam int unsigned BW   = $clog2(BPE);

    logic step_p, run_p, show_p, clear_p;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step  (.clk(clk), .rst_L(rst_L), .btn_i(btn_step),  .pulse_o(step_p));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_run   (.clk(clk), .rst_L(rst_L), .btn_i(btn_run),   .pulse_o(run_p));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_show  (.clk(clk), .rst_L(rst_L), .btn_i(btn_show),  .pulse_o(show_p));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clear (.clk(clk), .rst_L(rst_L), .btn_i(btn_clear), .pulse_o(clear_p));

    ck_state_e       ck_q, ck_d;
    disp_state_e     disp_q, disp_d;
    logic [HW-1:0]   half_q, half_d;
    logic            phi0_q, phi0_d;
    logic            running_q, running_d;
    logic            overflow_q, overflow_d;
    logic            dumping_q, dumping_d;
    logic            lcd_start_q, lcd_start_d;
    logic [7:0]      lcd_data_q, lcd_data_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   dump_idx_q, dump_idx_d;
    logic [BW-1:0]   byte_idx_q, byte_idx_d;
    logic [CNTW-1:0] count_q, count_d;
    logic [EW-1:0]   mem_q [DEPTH];

    logic            capture_c, clear_c, mem_we_c;
    logic [EW-1:0]   sel_entry_c;
    logic [BW+2:0]   shamt_c;
`ifdef CPU_DEBUG_MONITOR_BREAKPOINT_EN
    logic            bp_hit_q, bp_hit_d;
`else
    logic            unused_c;
    assign unused_c = bus.cpu_sync;
`endif

    always_comb begin
        ck_d        = ck_q;
        half_d      = half_q;
        running_d   = running_q;
        overflow_d  = overflow_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        disp_d      = disp_q;
        dumping_d   = dumping_q;
        dump_idx_d  = dump_idx_q;
        byte_idx_d  = byte_idx_q;
        lcd_data_d  = lcd_data_q;
        capture_c   = 1'b0;
        clear_c     = clear_p & ~dumping_q;
        sel_entry_c = mem_q[PW'(rd_ptr_q + dump_idx_q)];
        shamt_c     = {BW'(BPE - 1) - byte_idx_q, 3'b000};
`ifdef CPU_DEBUG_MONITOR_BREAKPOINT_EN
        bp_hit_d    = bp_hit_q;
`endif

        // phi0 generator; once started a HIGH+LOW pair always runs to completion
        unique case (ck_q)
            CK_IDLE: begin
                if (!dumping_q && (running_q || step_p)) begin
                    ck_d   = CK_HIGH;
                    half_d = '0;
                end
            end
            CK_HIGH: begin
                if (half_q == HW'(HALF_CYCLES - 1)) begin
                    ck_d      = CK_LOW;
                    half_d    = '0;
                    capture_c = 1'b1;
                end else begin
                    half_d = half_q + HW'(1);
                end
            end
            CK_LOW: begin
                if (half_q == HW'(HALF_CYCLES - 1)) begin
                    ck_d   = (running_q && !dumping_q) ? CK_HIGH : CK_IDLE;
                    half_d = '0;
                end else begin
                    half_d = half_q + HW'(1);
                end
            end
            default: ck_d = CK_IDLE;
        endcase

        mem_we_c = capture_c & ~clear_c;

        if (run_p) running_d = ~running_q;

        // Trace bookkeeping; a full buffer drops its oldest entry
        if (clear_c) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else if (capture_c) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (count_q == CNTW'(DEPTH)) begin
                rd_ptr_d   = rd_ptr_q + PW'(1);
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + CNTW'(1);
            end
        end

        // Dump waits in D_LOAD until any in-flight CPU cycle has finished
        unique case (disp_q)
            D_IDLE: begin
                if (show_p && (count_q != '0) && !clear_p) begin
                    disp_d     = D_LOAD;
                    dumping_d  = 1'b1;
                    running_d  = 1'b0;
                    dump_idx_d = '0;
                    byte_idx_d = '0;
                end
            end
            D_LOAD: begin
                if (ck_q == CK_IDLE) begin
                    lcd_data_d = 8'(sel_entry_c >> shamt_c);
                    disp_d     = D_START;
                end
            end
            D_START: disp_d = D_WAIT;
            D_WAIT: begin
                if (bus.lcd_write_done) begin
                    if (byte_idx_q == BW'(BPE - 1)) begin
                        byte_idx_d = '0;
                        if (dump_idx_q == PW'(count_q - CNTW'(1))) begin
                            disp_d    = D_IDLE;
                            dumping_d = 1'b0;
                        end else begin
                            dump_idx_d = dump_idx_q + PW'(1);
                            disp_d     = D_LOAD;
                        end
                    end else begin
                        byte_idx_d = byte_idx_q + BW'(1);
                        disp_d     = D_LOAD;
                    end
                end
            end
            default: disp_d = D_IDLE;
        endcase

`ifdef CPU_DEBUG_MONITOR_BREAKPOINT_EN
        if (run_p || clear_c) bp_hit_d = 1'b0;
        if (mem_we_c && running_q && bus.cpu_sync && (bus.cpu_ab == bp_addr)) begin
            running_d = 1'b0;
            bp_hit_d  = 1'b1;
        end
`endif

        phi0_d      = (ck_d == CK_HIGH);
        lcd_start_d = (disp_d == D_START);
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            ck_q        <= CK_IDLE;
            half_q      <= '0;
            phi0_q      <= 1'b0;
            running_q   <= 1'b0;
            overflow_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            disp_q      <= D_IDLE;
            dumping_q   <= 1'b0;
            dump_idx_q  <= '0;
            byte_idx_q  <= '0;
            lcd_data_q  <= '0;
            lcd_start_q <= 1'b0;
`ifdef CPU_DEBUG_MONITOR_BREAKPOINT_EN
            bp_hit_q    <= 1'b0;
`endif
        end else begin
            ck_q        <= ck_d;
            half_q      <= half_d;
            phi0_q      <= phi0_d;
            running_q   <= running_d;
            overflow_q  <= overflow_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            disp_q      <= disp_d;
            dumping_q   <= dumping_d;
            dump_idx_q  <= dump_idx_d;
            byte_idx_q  <= byte_idx_d;
            lcd_data_q  <= lcd_data_d;
            lcd_start_q <= lcd_start_d;
`ifdef CPU_DEBUG_MONITOR_BREAKPOINT_EN
            bp_hit_q    <= bp_hit_d;
`endif
        end
    end

    // Trace storage needs no reset; only entries covered by count are ever read
    always_ff @(posedge clk) begin
        if (mem_we_c) mem_q[wr_ptr_q] <= {bus.cpu_rw, bus.cpu_ab, bus.cpu_db};
    end

    assign bus.phi0_out        = phi0_q;
    assign bus.lcd_data        = lcd_data_q;
    assign bus.lcd_write_start = lcd_start_q;
    assign running             = running_q;
    assign trace_count         = count_q;
    assign overflow            = overflow_q;
    assign dumping             = dumping_q;
`ifdef CPU_DEBUG_MONITOR_BREAKPOINT_EN
    assign bp_hit              = bp_hit_q;
`endif

endmodule

// File: tb/tb_cpu_debug_monitor.sv
// Directed bench for cpu_debug_monitor (DEPTH=4, DEB_CYCLES=4, HALF_CYCLES=2).
module tb_cpu_debug_monitor;
    localparam int unsigned AW    = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned DEB   = 4;
    localparam int unsigned HALF  = 2;
    localparam int unsigned CNTW  = $clog2(DEPTH + 1);

    logic            clk = 1'b0;
    logic            rst_L;
    logic            btn_step, btn_run, btn_show, btn_clear;
    logic            running, overflow, dumping;
    logic [CNTW-1:0] trace_count;
`ifdef CPU_DEBUG_MONITOR_BREAKPOINT_EN
    logic [AW-1:0]   bp_addr;
    logic            bp_hit;
`endif

    cpu_debug_monitor_if #(.AW(AW)) bus ();

    cpu_debug_monitor #(.AW(AW), .DEPTH(DEPTH), .DEB_CYCLES(DEB), .HALF_CYCLES(HALF)) dut (
        .clk(clk), .rst_L(rst_L),
        .btn_step(btn_step), .btn_run(btn_run), .btn_show(btn_show), .btn_clear(btn_clear),
        .bus(bus),
`ifdef CPU_DEBUG_MONITOR_BREAKPOINT_EN
        .bp_addr(bp_addr), .bp_hit(bp_hit),
`endif
        .running(running), .trace_count(trace_count), .overflow(overflow), .dumping(dumping)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // CPU bus model: in auto mode AB/DB follow the phi0 cycle index since ab_base
    logic          ab_auto;
    logic [AW-1:0] ab_man;
    logic [7:0]    db_man;
    int            ab_base;
    int            rise_cnt  = 0;
    int            cyc_idx   = 0;
    int            high_run  = 0;
    int            last_high = 0;
    logic          phi_prev  = 1'b0;
    logic [7:0]    lcd_log [$];

    assign bus.cpu_ab = ab_auto ? AW'(cyc_idx - ab_base) : ab_man;
    assign bus.cpu_db = ab_auto ? 8'(32'h50 + cyc_idx - ab_base) : db_man;

    always @(negedge clk) begin
        if (bus.phi0_out && !phi_prev) begin
            cyc_idx  <= rise_cnt;
            rise_cnt <= rise_cnt + 1;
            high_run <= 1;
        end else if (bus.phi0_out) begin
            high_run <= high_run + 1;
        end
        if (!bus.phi0_out && phi_prev) last_high <= high_run;
        phi_prev <= bus.phi0_out;
        if (bus.lcd_write_start) lcd_log.push_back(bus.lcd_data);
    end

    // LCD model: done for one clk, three clk after each start
    initial begin
        bus.lcd_write_done = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.lcd_write_start) begin
                repeat (2) @(negedge clk);
                bus.lcd_write_done = 1'b1;
                @(negedge clk);
                bus.lcd_write_done = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // mask = {clear, show, run, step}
    task automatic press(input logic [3:0] mask, input int hold);
        @(negedge clk);
        {btn_clear, btn_show, btn_run, btn_step} = mask;
        repeat (hold) @(negedge clk);
        {btn_clear, btn_show, btn_run, btn_step} = 4'b0000;
    endtask

    task automatic wait_dumping(input logic lvl, input int budget, input string tag);
        int n = 0;
        while (dumping !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(dumping), 32'(lvl));
    endtask

    task automatic wait_running(input logic lvl, input int budget, input string tag);
        int n = 0;
        while (running !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(running), 32'(lvl));
    endtask

    task automatic wait_rises(input int target, input int budget, input string tag);
        int n = 0;
        while (rise_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(rise_cnt >= target), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r0;
        int l0;
        rst_L        = 1'b0;
        {btn_clear, btn_show, btn_run, btn_step} = 4'b0000;
        ab_auto      = 1'b0;
        ab_man       = '0;
        db_man       = '0;
        ab_base      = 0;
        bus.cpu_rw   = 1'b0;
        bus.cpu_sync = 1'b0;
`ifdef CPU_DEBUG_MONITOR_BREAKPOINT_EN
        bp_addr      = 16'h0003;
`endif
        repeat (3) @(negedge clk);
        check("rst_phi0", 32'(bus.phi0_out), 32'd0);
        check("rst_running", 32'(running), 32'd0);
        check("rst_count", 32'(trace_count), 32'd0);
        check("rst_lcd", {22'd0, bus.lcd_data, bus.lcd_write_start, overflow, dumping}, 32'd0);
        rst_L = 1'b1;
        repeat (3) @(negedge clk);

        // single step
        ab_man = 16'h1234; db_man = 8'hA9; bus.cpu_rw = 1'b1;
        r0 = rise_cnt;
        press(4'b0001, 10);
        repeat (25) @(negedge clk);
        check("step_pulses", 32'(rise_cnt - r0), 32'd1);
        check("step_high_len", 32'(last_high), 32'd2);
        check("step_count", 32'(trace_count), 32'd1);

        // dump of the single entry
        l0 = lcd_log.size();
        press(4'b0100, 8);
        wait_dumping(1'b1, 20, "step_dump_start");
        wait_dumping(1'b0, 200, "step_dump_end");
        check("step_dump_n", 32'(lcd_log.size() - l0), 32'd3);
        check("step_b0", 32'(lcd_log[l0]), 32'h12);
        check("step_b1", 32'(lcd_log[l0 + 1]), 32'h34);
        check("step_b2", 32'(lcd_log[l0 + 2]), 32'hA9);
        check("step_count_kept", 32'(trace_count), 32'd1);

        press(4'b1000, 8);
        repeat (10) @(negedge clk);
        check("clear_count", 32'(trace_count), 32'd0);

        // bouncing step button is rejected
        r0 = rise_cnt;
        for (int i = 0; i < 10; i++) begin
            btn_step = ~btn_step;
            repeat (2) @(negedge clk);
        end
        btn_step = 1'b0;
        repeat (20) @(negedge clk);
        check("bounce_pulses", 32'(rise_cnt - r0), 32'd0);

        // free run with overflow
        ab_base = rise_cnt; ab_auto = 1'b1;
        r0 = rise_cnt;
        press(4'b0010, 8);
        wait_running(1'b1, 10, "run_on");
        wait_rises(r0 + 4, 60, "run_progress");
        press(4'b0010, 8);
        wait_running(1'b0, 40, "run_off");
        repeat (10) @(negedge clk);
        check("run_cycles", 32'(rise_cnt - r0), 32'd6);
        check("run_count", 32'(trace_count), 32'd4);
        check("run_overflow", 32'(overflow), 32'd1);

        // dump oldest-first: AB 2..5
        l0 = lcd_log.size();
        press(4'b0100, 8);
        wait_dumping(1'b1, 20, "dump_start");
        wait_dumping(1'b0, 400, "dump_end");
        check("dump_n", 32'(lcd_log.size() - l0), 32'd12);
        for (int i = 0; i < 4; i++) begin
            check("dump_ab_hi", 32'(lcd_log[l0 + 3*i]), 32'h00);
            check("dump_ab_lo", 32'(lcd_log[l0 + 3*i + 1]), 32'(2 + i));
            check("dump_db", 32'(lcd_log[l0 + 3*i + 2]), 32'(8'h52 + i));
        end
        check("dump_count_kept", 32'(trace_count), 32'd4);

        // step and clear are ignored while dumping
        r0 = rise_cnt;
        l0 = lcd_log.size();
        press(4'b0100, 8);
        wait_dumping(1'b1, 20, "lock_dump_start");
        press(4'b1001, 8);
        wait_dumping(1'b0, 400, "lock_dump_end");
        repeat (10) @(negedge clk);
        check("lock_pulses", 32'(rise_cnt - r0), 32'd0);
        check("lock_count", 32'(trace_count), 32'd4);
        check("lock_bytes", 32'(lcd_log.size() - l0), 32'd12);
        check("lock_overflow", 32'(overflow), 32'd1);

        press(4'b1000, 8);
        repeat (10) @(negedge clk);
        check("clear2_count", 32'(trace_count), 32'd0);
        check("clear2_overflow", 32'(overflow), 32'd0);

        // show on an empty trace does nothing
        l0 = lcd_log.size();
        press(4'b0100, 8);
        repeat (20) @(negedge clk);
        check("empty_bytes", 32'(lcd_log.size() - l0), 32'd0);
        check("empty_dumping", 32'(dumping), 32'd0);

`ifdef CPU_DEBUG_MONITOR_BREAKPOINT_EN
        // breakpoint at AB=3
        bus.cpu_sync = 1'b1;
        ab_base = rise_cnt; ab_auto = 1'b1;
        r0 = rise_cnt;
        press(4'b0010, 8);
        wait_running(1'b1, 10, "bp_run_on");
        wait_running(1'b0, 100, "bp_run_off");
        repeat (10) @(negedge clk);
        check("bp_hit", 32'(bp_hit), 32'd1);
        check("bp_cycles", 32'(rise_cnt - r0), 32'd4);
        check("bp_count", 32'(trace_count), 32'd4);
        press(4'b1000, 8);
        repeat (10) @(negedge clk);
        check("bp_hit_cleared", 32'(bp_hit), 32'd0);
        check("bp_clear_count", 32'(trace_count), 32'd0);
        bus.cpu_sync = 1'b0;
`endif

        // asynchronous reset in the middle of a dump
        ab_auto = 1'b0;
        press(4'b0001, 8);
        repeat (20) @(negedge clk);
        check("pre_rst_count", 32'(trace_count), 32'd1);
        press(4'b0100, 8);
        wait_dumping(1'b1, 20, "rst_dump_start");
        repeat (3) @(negedge clk);
        #2 rst_L = 1'b0;
        #1;
        check("arst_dumping", 32'(dumping), 32'd0);
        check("arst_count", 32'(trace_count), 32'd0);
        check("arst_misc", {22'd0, bus.lcd_data, bus.lcd_write_start, bus.phi0_out}, 32'd0);
        check("arst_flags", {30'd0, running, overflow}, 32'd0);
`ifdef CPU_DEBUG_MONITOR_BREAKPOINT_EN
        check("arst_bp_hit", 32'(bp_hit), 32'd0);
`endif
        @(negedge clk);
        rst_L = 1'b1;
        repeat (10) @(negedge clk);
        check("post_rst_dumping", 32'(dumping), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
